// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud divisor sequencing, rx byte FIFO, overrun and idle timeout
module uart_rx_ctrl #(
  parameter int WIDTH      = 10,
  parameter int DBIT       = 8,
  parameter int DEPTH      = 4,
  parameter int IDLE_TICKS = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_divisor,
  input  logic             s_tick,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_dout,
  output logic [WIDTH-1:0] final_value,
  output logic             enable,
  output logic             rd_valid,
  output logic [DBIT-1:0]  rd_data,
  input  logic             rd_ready,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic             idle_timeout,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(IDLE_TICKS + 1);
  localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_TICKS);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TICKS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_RECONF} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] fv_q, fv_d;
  logic             rc_cnt_q, rc_cnt_d;
  logic             enable_q, busy_q;

  logic [DBIT-1:0]  mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop, push_ok, drop;
  logic             overrun_q, overrun_d;

  logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             armed_q, armed_d;
  logic             reach;
  logic             idle_q, idle_d;

  // Divisor sequencing: a run-time divisor change holds the generator off for two cycles
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    fv_d     = fv_q;
    rc_cnt_d = rc_cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (cfg_wr) begin
          fv_d     = cfg_divisor;
          shadow_d = cfg_divisor;
        end
        if (cfg_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_en) begin
          state_d = ST_OFF;
          if (cfg_wr) begin
            fv_d     = cfg_divisor;
            shadow_d = cfg_divisor;
          end
        end else if (cfg_wr) begin
          state_d  = ST_RECONF;
          shadow_d = cfg_divisor;
          fv_d     = cfg_divisor;
          rc_cnt_d = 1'b0;
        end
      end
      ST_RECONF: begin
        if (cfg_wr) begin
          shadow_d = cfg_divisor;
          fv_d     = cfg_divisor;
          rc_cnt_d = 1'b0;
        end else if (rc_cnt_q) begin
          state_d  = cfg_en ? ST_RUN : ST_OFF;
          rc_cnt_d = 1'b0;
        end else begin
          rc_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = rx_done_tick && (state_q == ST_RUN);
  assign pop        = !fifo_empty && rd_ready;
  // When full, a simultaneous pop frees the slot being written this edge
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;
  assign wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign overrun_d  = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    reach     = 1'b0;
    if (rx_done_tick || (state_q != ST_RUN)) begin
      tmo_cnt_d = '0;
    end else if (s_tick && (tmo_cnt_q != IDLE_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      reach     = (tmo_cnt_q == IDLE_LAST);
    end
  end

  assign armed_d = rx_done_tick ? 1'b1 : (reach ? 1'b0 : armed_q);
  assign idle_d  = reach && armed_q && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_OFF;
      shadow_q  <= '0;
      fv_q      <= '0;
      rc_cnt_q  <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      tmo_cnt_q <= '0;
      armed_q   <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      fv_q      <= fv_d;
      rc_cnt_q  <= rc_cnt_d;
      enable_q  <= (state_d == ST_RUN);
      busy_q    <= (state_d == ST_RECONF);
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      tmo_cnt_q <= tmo_cnt_d;
      armed_q   <= armed_d;
      idle_q    <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_dout;
  end

  assign final_value  = fv_q;
  assign enable       = enable_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign idle_timeout = idle_q;
  assign rd_valid     = !fifo_empty;
  assign rd_data      = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_en = 1'b0, cfg_wr = 1'b0;
  logic [9:0] cfg_divisor = '0;
  logic       s_tick = 1'b0, rx_done_tick = 1'b0;
  logic [7:0] rx_dout = '0;
  logic [9:0] final_value;
  logic       enable, rd_valid, rd_ready = 1'b0, ovr_clr = 1'b0;
  logic [7:0] rd_data;
  logic       overrun, idle_timeout, busy;

  int checks = 0;
  int failures = 0;
  int idle_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.WIDTH(10), .DBIT(8), .DEPTH(4), .IDLE_TICKS(160)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_wr(cfg_wr),
    .cfg_divisor(cfg_divisor), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
    .rx_dout(rx_dout), .final_value(final_value), .enable(enable),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .ovr_clr(ovr_clr), .overrun(overrun), .idle_timeout(idle_timeout), .busy(busy)
  );

  // Monitor: every accepted pop is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h expected=none", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL pop_data got=%h expected=%h", rd_data, e);
        end
      end
    end
    if (!rst_n && idle_timeout) idle_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    rx_done_tick = 1'b1; rx_dout = b;
    if (accepted) exp_q.push_back(b);
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic ticks(input int n);
    s_tick = 1'b1;
    repeat (n) step();
    s_tick = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b0;
    check("rst_enable", enable, 0);
    check("rst_final", final_value, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_idle", idle_timeout, 0);

    cfg_wr = 1'b1; cfg_divisor = 10'h145;
    step();
    cfg_wr = 1'b0;
    check("off_load_final", final_value, 10'h145);
    check("off_enable", enable, 0);
    cfg_en = 1'b1;
    step();
    check("run_enable", enable, 1);

    cfg_wr = 1'b1; cfg_divisor = 10'h0A2;
    step();
    cfg_wr = 1'b0;
    check("reconf1_enable", enable, 0);
    check("reconf1_busy", busy, 1);
    check("reconf1_final", final_value, 10'h0A2);
    step();
    check("reconf2_enable", enable, 0);
    check("reconf2_busy", busy, 1);
    step();
    check("reconf3_enable", enable, 1);
    check("reconf3_busy", busy, 0);
    check("reconf3_final", final_value, 10'h0A2);

    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    check("head_11", rd_data, 8'h11);
    pop1(); pop1(); pop1();
    check("drained_valid", rd_valid, 0);

    push(8'hA1, 1); push(8'hA2, 1); push(8'hA3, 1); push(8'hA4, 1);
    check("full_no_ovr", overrun, 0);
    push(8'hA5, 0);
    check("ovr_set", overrun, 1);
    check("full_head", rd_data, 8'hA1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    rd_ready = 1'b1;
    push(8'hB6, 1);
    rd_ready = 1'b0;
    check("pushpop_no_ovr", overrun, 0);
    check("pushpop_head", rd_data, 8'hA2);
    repeat (4) pop1();
    check("after_full_valid", rd_valid, 0);

    push(8'h5A, 1);
    idle_cnt = 0;
    ticks(160);
    check("idle_one_pulse", idle_cnt, 1);
    ticks(400);
    check("idle_no_repeat", idle_cnt, 1);
    pop1();

    push(8'h6B, 1);
    pop1();
    idle_cnt = 0;
    ticks(160);
    check("idle_empty_none", idle_cnt, 0);

    push(8'h01, 1); push(8'h02, 1);
    rst_n = 1'b1; cfg_en = 1'b0;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    check("midrst_valid", rd_valid, 0);
    check("midrst_enable", enable, 0);
    check("midrst_final", final_value, 0);

    step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sits on top of the UART receiver/baud-generator pair. It sequences the pair: holds the programmed baud divisor, gates the baud generator enable, and performs a safe enable-drop/reload when the divisor is changed at run time. It also buffers received bytes in a small first-word-fall-through FIFO with a ready/valid read port, overrun flag and idle-line timeout.

## Interface
- WIDTH, 10: width of the baud divisor (`final_value`).
- DBIT, 8: data bits per frame.
- DEPTH, 4: FIFO depth in bytes; must be a power of 2 and ≥2.
- IDLE_TICKS, 160: number of `s_tick` pulses without a received byte before timeout (10 bit times at 16x oversampling); must be ≥1.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1).
- cfg_en  in  1  level; 1 = receiver running, 0 = stopped.
- cfg_wr  in  1  one-cycle strobe that writes `cfg_divisor`.
- cfg_divisor  in  WIDTH  new baud divisor.
- s_tick  in  1  baud tick from the generator; used only for timeout counting.
- rx_done_tick  in  1  byte-complete pulse from the receiver.
- rx_dout  in  DBIT  received byte, valid when `rx_done_tick` = 1.
- final_value  out  WIDTH  divisor driven to the baud generator.
- enable  out  1  baud generator enable.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DBIT  FIFO head byte.
- rd_ready  in  1  consumer accepts the head byte.
- ovr_clr  in  1  clears `overrun`.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- idle_timeout  out  1  one-cycle pulse on idle-line timeout.
- busy  out  1  1 while in `RECONF`.

## Operation
- FSM states: `OFF`, `RUN`, `RECONF`.
- `OFF`: `enable` = 0.
  - `cfg_wr` loads `final_value` directly.
  - `cfg_en` = 1 → `RUN`.
- `RUN`: `enable` = 1.
  - `cfg_en` = 0 → `OFF`.
  - `cfg_wr` → latch the divisor into a shadow register, go to `RECONF`.
  - If `cfg_en` falls in the same cycle as `cfg_wr`, `OFF` wins and the divisor loads directly.
- `RECONF`: `enable` = 0 for exactly 2 cycles.
  - `final_value` takes the shadow value on the first cycle.
  - Then → `RUN` if `cfg_en` = 1, else `OFF`.
  - `cfg_wr` during `RECONF` overwrites the shadow register and restarts the 2-cycle count.
- Push: `rx_done_tick` = 1 in `RUN` writes `rx_dout` to the FIFO. `rx_done_tick` in `OFF` or `RECONF` is ignored.
- Full FIFO:
  - A push with no pop drops the byte and sets `overrun`.
  - A push and a pop in the same cycle are both accepted; count is unchanged and `overrun` is not set.
- Pop: `rd_valid` && `rd_ready`. `rd_ready` while empty has no effect.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full/empty are decided by comparing the MSB and the lower bits.
- `overrun` stays set until `ovr_clr`. If `ovr_clr` and a new drop occur in the same cycle, `overrun` stays 1.
- Timeout counter:
  - Cleared on every `rx_done_tick` and whenever the state is not `RUN`.
  - Increments on `s_tick` in `RUN` and saturates at IDLE_TICKS.
  - `idle_timeout` pulses once in the cycle after the counter first reaches IDLE_TICKS, and only if the FIFO is non-empty at that point. The pulse re-arms only after the next `rx_done_tick`.
- FIFO contents are retained across `OFF`/`RECONF`; only reset flushes them.

## Timing
- Reset values:
  - state `OFF`; `enable` 0; `final_value` 0; shadow 0.
  - FIFO empty: `rd_valid` 0, `rd_data` 0 (memory not reset, output masked while empty).
  - `overrun` 0, `idle_timeout` 0, `busy` 0, timeout counter 0.
- Reset mid-operation aborts `RECONF` and discards FIFO contents on the next edge.
- `cfg_en` rise → `enable` = 1 one cycle later.
- `cfg_wr` in `RUN`: at edge N the state becomes `RECONF`. `enable` is 0 and `busy` is 1 for cycles N+1 and N+2, with the new `final_value` from N+1. `enable` returns to 1 at N+3.
- `rx_done_tick` at edge N → `rd_valid` = 1 and `rd_data` = byte after edge N (1-cycle latency).
- Pop at edge N → the next head byte is visible after edge N.
- All outputs are registered except `rd_valid` and `rd_data`, which are decoded from registered pointers and memory.

## Test plan
- Reset, then `cfg_divisor` = 0x145 with `cfg_wr` in `OFF`, then `cfg_en` = 1 → `final_value` = 0x145 next cycle, `enable` = 1 one cycle after `cfg_en`.
- In `RUN`, `cfg_wr` with 0x0A2 → `enable` low for exactly 2 cycles, `busy` high for the same 2 cycles, `final_value` = 0x0A2 during the gap, `enable` high again on the third cycle.
- Push 0x11, 0x22, 0x33 with `rd_ready` = 0 → `rd_data` = 0x11; then pop three times → 0x22, 0x33, then `rd_valid` = 0.
- DEPTH = 4: push 5 bytes with no pop → `overrun` = 1 and the FIFO holds the first 4. With the FIFO full, push and pop in the same cycle → no new overrun and the new byte ends up last. `ovr_clr` → `overrun` = 0.
- One byte held, then IDLE_TICKS `s_tick` pulses → exactly one `idle_timeout` pulse; 400 further ticks → no further pulse. With an empty FIFO the same sequence gives no pulse.
- Push 2 bytes, pulse `rst_n` for one cycle → `rd_valid` = 0, `enable` = 0, `final_value` = 0 on the next cycle.
